store_queue: RTL and testbench
==============================

// Module: store_queue
// PURPOSE
//  FIFO between the mem stage's store address/data output and the data-memory port.
//  - Holds stores in program order until retirement (commit), then drains them to memory.
//  - Flush drops speculative (uncommitted) entries.
//  - Gives younger loads store-to-load forwarding from queued stores.
// PARAMETERS
//  DEPTH   8                 number of entries (power of 2, >=2)
//  IDX_W   $clog2(DEPTH)     pointer index width; pointers carry one extra wrap bit
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       asynchronous, active-low reset
//  enq_valid      in   1       mem stage offers a store
//  enq_ready      out  1       queue can accept (count < DEPTH)
//  enq_addr       in   32      effective store address (rs1+imm)
//  enq_data       in   32      store data (rs2)
//  enq_size       in   2       0=byte 1=half 2=word (3 illegal, treated as word)
//  commit_valid   in   1       oldest uncommitted store retires this cycle
//  flush          in   1       squash all uncommitted entries
//  mem_req_valid  out  1       committed head store presented to memory
//  mem_req_addr   out  32      head address
//  mem_req_data   out  32      head data
//  mem_req_size   out  2       head size
//  mem_req_ack    in   1       memory accepted head this cycle
//  fwd_addr       in   32      load address to check
//  fwd_hit        out  1       forward fwd_data to the load
//  fwd_data       out  32      forwarded word
//  fwd_stall      out  1       partial-overlap match; load must wait
//  count          out  IDX_W+1 occupied entries
// BEHAVIOUR
//  - Pointers (IDX_W+1 bits, wrap bit in MSB):
//    - head: oldest entry; cmt: first uncommitted entry; tail: next free slot.
//    - Invariant: head <= cmt <= tail in FIFO order.
//  - Reset (async, on low): head=cmt=tail=0. Hence count=0, enq_ready=1, mem_req_valid=0, fwd_hit=0, fwd_stall=0.
//    - Takes effect immediately, including mid-drain; entry storage is not cleared.
//  - Enqueue: on edge when enq_valid & enq_ready & !flush -> write entry at tail, tail++.
//    - Zero latency to queue; enq_ready derives from registered count only (no same-cycle drain credit).
//  - Commit: on edge when commit_valid & (cmt != tail) -> cmt++.
//    - commit_valid with no uncommitted entry is ignored.
//    - One commit per cycle.
//  - Drain: combinational outputs from the head entry.
//    - mem_req_valid = (head != cmt); addr/data/size = entry[head].
//    - Outputs stay stable while mem_req_valid & !mem_req_ack.
//    - On edge with mem_req_valid & mem_req_ack -> head++. The next committed entry is presented the following cycle.
//    - Back-to-back acks give 1 store/cycle.
//    - Ack while !mem_req_valid is ignored.
//  - Flush: on edge, tail <= cmt after this cycle's commit is applied.
//    - So a same-cycle commit survives; the same-cycle enqueue is dropped.
//    - Committed entries keep draining; a same-cycle ack still advances head.
//  - Simultaneous enq + commit + ack: all apply in the same edge; count = tail - head (mod 2^(IDX_W+1)).
//  - Forwarding (combinational): scan entries head..tail-1, youngest first; first entry with addr[31:2]==fwd_addr[31:2] decides.
//    - Word-size match with addr==fwd_addr: fwd_hit=1, fwd_data=its data.
//    - Any other match (byte/half, or misaligned): fwd_stall=1, fwd_hit=0.
//    - No match: both 0; fwd_data=0.
//    - Committed entries not yet drained participate.
//  - Wrap-around: pointer index = low IDX_W bits.
//    - full = (index equal & wrap bit differs); empty = (tail == head).
// TESTING
//  1 Reset mid-op: enqueue 3, commit 2, hold mem_req_ack=0, pull reset low between edges
//    -> immediately count=0, mem_req_valid=0, enq_ready=1.
//  2 Full: enqueue 8 with no commit -> enq_ready=0, 9th store not written.
//    - Then commit 1 + ack 1 -> count=7, enq_ready=1 next cycle.
//  3 Backpressure: enqueue (0x100, 0xDEADBEEF, word), commit, ack low for 3 cycles
//    -> mem_req_valid=1 with stable addr/data all 3 cycles; head advances on the ack cycle; empty after.
//  4 Flush: 2 committed + 3 uncommitted, flush with commit_valid=1 and enq_valid=1
//    -> count=3, exactly 3 stores drain in order, enqueued store absent.
//  5 Forward: store 0x200=1 then 0x200=2, fwd_addr=0x200 -> fwd_hit=1, fwd_data=2.
//    - Byte store at 0x205, fwd_addr=0x204 -> fwd_stall=1, fwd_hit=0.
//  6 Wrap: 20 stores with enq/commit/ack asserted every cycle
//    -> memory sees all 20 in order with no drops or duplicates; count never exceeds 8.

Source files
------------

// File: rtl/store_queue.sv
// Store queue between the mem stage and the data-memory port: holds stores in program
// order, drains committed ones to memory, squashes uncommitted ones on flush, and forwards to loads.
module store_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_addr,
    input  logic [31:0]      enq_data,
    input  logic [1:0]       enq_size,
    input  logic             commit_valid,
    input  logic             flush,
    output logic             mem_req_valid,
    output logic [31:0]      mem_req_addr,
    output logic [31:0]      mem_req_data,
    output logic [1:0]       mem_req_size,
    input  logic             mem_req_ack,
    input  logic [31:0]      fwd_addr,
    output logic             fwd_hit,
    output logic [31:0]      fwd_data,
    output logic             fwd_stall,
    output logic [IDX_W:0]   count
);
    localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

    // Pointers carry an extra wrap bit in the MSB to tell full from empty.
    logic [IDX_W:0] head, cmt, tail;
    logic [IDX_W:0] cmt_next;
    logic [31:0]    addr_mem [DEPTH];
    logic [31:0]    data_mem [DEPTH];
    logic [1:0]     size_mem [DEPTH];
    logic           full, do_enq, do_cmt, do_deq;
    logic [IDX_W:0]   scan_off;
    logic [IDX_W-1:0] scan_slot;

    assign count         = tail - head;
    assign full          = (tail[IDX_W-1:0] == head[IDX_W-1:0]) && (tail[IDX_W] != head[IDX_W]);
    assign enq_ready     = !full;
    assign mem_req_valid = (head != cmt);
    assign mem_req_addr  = addr_mem[head[IDX_W-1:0]];
    assign mem_req_data  = data_mem[head[IDX_W-1:0]];
    assign mem_req_size  = size_mem[head[IDX_W-1:0]];

    assign do_enq   = enq_valid && enq_ready && !flush;
    assign do_cmt   = commit_valid && (cmt != tail);
    assign do_deq   = mem_req_valid && mem_req_ack;
    assign cmt_next = do_cmt ? cmt + PTR_ONE : cmt;

    // Flush rewinds tail to the post-commit cmt, so a same-cycle commit survives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            cmt  <= '0;
            tail <= '0;
        end else begin
            if (do_deq)
                head <= head + PTR_ONE;
            cmt <= cmt_next;
            if (flush)
                tail <= cmt_next;
            else if (do_enq)
                tail <= tail + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_enq) begin
            addr_mem[tail[IDX_W-1:0]] <= enq_addr;
            data_mem[tail[IDX_W-1:0]] <= enq_data;
            size_mem[tail[IDX_W-1:0]] <= enq_size;
        end
    end

    // Scan oldest to youngest; a later match overrides, so the youngest matching entry decides.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_stall = 1'b0;
        fwd_data  = '0;
        scan_off  = '0;
        scan_slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_off  = (IDX_W+1)'(i);
            scan_slot = head[IDX_W-1:0] + scan_off[IDX_W-1:0];
            if ((scan_off < count) && (addr_mem[scan_slot][31:2] == fwd_addr[31:2])) begin
                if (size_mem[scan_slot][1] && (addr_mem[scan_slot] == fwd_addr)) begin
                    fwd_hit   = 1'b1;
                    fwd_stall = 1'b0;
                    fwd_data  = data_mem[scan_slot];
                end else begin
                    fwd_hit   = 1'b0;
                    fwd_stall = 1'b1;
                    fwd_data  = '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_store_queue;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enq_valid = 1'b0;
    logic             enq_ready;
    logic [31:0]      enq_addr = '0;
    logic [31:0]      enq_data = '0;
    logic [1:0]       enq_size = '0;
    logic             commit_valid = 1'b0;
    logic             flush = 1'b0;
    logic             mem_req_valid;
    logic [31:0]      mem_req_addr;
    logic [31:0]      mem_req_data;
    logic [1:0]       mem_req_size;
    logic             mem_req_ack = 1'b0;
    logic [31:0]      fwd_addr = '0;
    logic             fwd_hit;
    logic [31:0]      fwd_data;
    logic             fwd_stall;
    logic [IDX_W:0]   count;

    store_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_addr(enq_addr), .enq_data(enq_data), .enq_size(enq_size),
        .commit_valid(commit_valid), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_size(mem_req_size),
        .mem_req_ack(mem_req_ack),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .fwd_stall(fwd_stall), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } ent_t;

    ent_t        mq[$];
    int          mcmt = 0;
    logic [31:0] drained[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          max_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a program-ordered list of stores plus the number already committed.
    always @(posedge clock or negedge reset) begin
        logic m_ready;
        if (!reset) begin
            mq.delete();
            mcmt = 0;
        end else begin
            m_ready = (mq.size() < DEPTH);
            if ((mcmt > 0) && mem_req_ack) begin
                void'(mq.pop_front());
                mcmt--;
            end
            if (commit_valid && (mcmt < mq.size()))
                mcmt++;
            if (flush) begin
                while (mq.size() > mcmt)
                    void'(mq.pop_back());
            end else if (enq_valid && m_ready) begin
                mq.push_back('{enq_addr, enq_data, enq_size});
            end
        end
    end

    always @(negedge clock) begin
        logic        e_hit, e_stall;
        logic [31:0] e_data;
        if (reset) begin
            check("count", 32'(count), 32'(mq.size()));
            check("enq_ready", 32'(enq_ready), 32'(mq.size() < DEPTH));
            check("mem_req_valid", 32'(mem_req_valid), 32'(mcmt > 0));
            if (mcmt > 0) begin
                check("mem_req_addr", mem_req_addr, mq[0].addr);
                check("mem_req_data", mem_req_data, mq[0].data);
                check("mem_req_size", 32'(mem_req_size), 32'(mq[0].size));
            end
            e_hit = 1'b0; e_stall = 1'b0; e_data = '0;
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].addr[31:2] == fwd_addr[31:2]) begin
                    if ((mq[i].size >= 2'd2) && (mq[i].addr == fwd_addr)) begin
                        e_hit = 1'b1;
                        e_data = mq[i].data;
                    end else begin
                        e_stall = 1'b1;
                    end
                    break;
                end
            end
            check("fwd_hit", 32'(fwd_hit), 32'(e_hit));
            check("fwd_stall", 32'(fwd_stall), 32'(e_stall));
            check("fwd_data", fwd_data, e_data);
            if (mem_req_valid && mem_req_ack)
                drained.push_back(mem_req_addr);
            if (int'(count) > max_count)
                max_count = int'(count);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        enq_valid = 1'b1; enq_addr = a; enq_data = d; enq_size = s;
        step();
        enq_valid = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_count", 32'(count), 32'd0);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        check("rst_fwd_stall", 32'(fwd_stall), 32'd0);
        #9 reset = 1'b1;
        step();

        // Reset in the middle of a stalled drain
        enq(32'h10, 32'hA0, 2'd2);
        enq(32'h14, 32'hA1, 2'd2);
        enq(32'h18, 32'hA2, 2'd2);
        commit_valid = 1'b1; step(); step(); commit_valid = 1'b0;
        check("t1_count_before", 32'(count), 32'd3);
        check("t1_valid_before", 32'(mem_req_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t1_count", 32'(count), 32'd0);
        check("t1_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("t1_enq_ready", 32'(enq_ready), 32'd1);
        step();
        reset = 1'b1;
        step();

        // Fill to capacity
        for (int i = 0; i < 8; i++)
            enq(32'h300 + 32'(4 * i), 32'(i), 2'd2);
        check("t2_count_full", 32'(count), 32'd8);
        check("t2_enq_ready_full", 32'(enq_ready), 32'd0);
        enq(32'h3FC, 32'h99, 2'd2);
        check("t2_ninth_dropped", 32'(count), 32'd8);
        commit_valid = 1'b1; step(); commit_valid = 1'b0;
        mem_req_ack = 1'b1; step(); mem_req_ack = 1'b0;
        check("t2_count_after", 32'(count), 32'd7);
        check("t2_enq_ready_after", 32'(enq_ready), 32'd1);
        flush = 1'b1; step(); flush = 1'b0;
        check("t2_flushed", 32'(count), 32'd0);

        // Memory backpressure
        enq(32'h100, 32'hDEADBEEF, 2'd2);
        commit_valid = 1'b1; step(); commit_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_valid_held", 32'(mem_req_valid), 32'd1);
            check("t3_addr_held", mem_req_addr, 32'h100);
            check("t3_data_held", mem_req_data, 32'hDEADBEEF);
            step();
        end
        mem_req_ack = 1'b1; step(); mem_req_ack = 1'b0;
        check("t3_empty_valid", 32'(mem_req_valid), 32'd0);
        check("t3_empty_count", 32'(count), 32'd0);

        // Flush with a same-cycle commit and enqueue
        for (int i = 0; i < 5; i++)
            enq(32'h400 + 32'(4 * i), 32'h40 + 32'(i), 2'd2);
        commit_valid = 1'b1; step(); step(); commit_valid = 1'b0;
        flush = 1'b1; commit_valid = 1'b1;
        enq_valid = 1'b1; enq_addr = 32'h4FC; enq_data = 32'h4F; enq_size = 2'd2;
        step();
        flush = 1'b0; commit_valid = 1'b0; enq_valid = 1'b0;
        check("t4_count", 32'(count), 32'd3);
        drained.delete();
        mem_req_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        mem_req_ack = 1'b0;
        check("t4_drain_n", 32'(drained.size()), 32'd3);
        check("t4_drain0", drained.size() > 0 ? drained[0] : 32'hFFFF_FFFF, 32'h400);
        check("t4_drain1", drained.size() > 1 ? drained[1] : 32'hFFFF_FFFF, 32'h404);
        check("t4_drain2", drained.size() > 2 ? drained[2] : 32'hFFFF_FFFF, 32'h408);
        check("t4_empty", 32'(count), 32'd0);

        // Store-to-load forwarding
        enq(32'h200, 32'd1, 2'd2);
        enq(32'h200, 32'd2, 2'd2);
        fwd_addr = 32'h200; #1;
        check("t5_hit", 32'(fwd_hit), 32'd1);
        check("t5_data", fwd_data, 32'd2);
        check("t5_nostall", 32'(fwd_stall), 32'd0);
        enq(32'h205, 32'hAB, 2'd0);
        fwd_addr = 32'h204; #1;
        check("t5_stall", 32'(fwd_stall), 32'd1);
        check("t5_stall_nohit", 32'(fwd_hit), 32'd0);
        fwd_addr = 32'h200; #1;
        check("t5_hit_again", fwd_data, 32'd2);
        flush = 1'b1; step(); flush = 1'b0;
        fwd_addr = 32'h0;

        // Streaming around the pointer wrap
        drained.delete();
        max_count = 0;
        commit_valid = 1'b1; mem_req_ack = 1'b1;
        for (int i = 0; i < 20; i++)
            enq(32'h1000 + 32'(4 * i), 32'h500 + 32'(i), 2'd2);
        for (int i = 0; i < 5; i++) step();
        commit_valid = 1'b0; mem_req_ack = 1'b0;
        check("t6_drain_n", 32'(drained.size()), 32'd20);
        for (int i = 0; i < 20; i++)
            check("t6_drain_order", drained.size() > i ? drained[i] : 32'hFFFF_FFFF, 32'h1000 + 32'(4 * i));
        check("t6_max_count_le8", 32'(max_count <= 8), 32'd1);
        check("t6_empty", 32'(count), 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
